datapath_gray_param: RTL and testbench



---
 rtl/datapath_gray_param_if.sv | 28 ++
 rtl/datapath_gray_param.sv | 159 +++++++++++++++
 tb/tb_datapath_gray_param.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_gray_param_if.sv
`default_nettype none
// ============================================================================
// datapath_gray_param_if: pixel-in / gray-out stream bundle with backpressure.
// Revision: 1.0
// ============================================================================
interface datapath_gray_param_if #(
    parameter int C_DATA_WIDTH = 8
) ();
    logic [C_DATA_WIDTH-1:0] data_in;
    logic                    valid_in;
    logic                    sof_in;
    logic                    busy_out;
    logic [C_DATA_WIDTH-1:0] data_out;
    logic                    valid_out;
    logic                    sof_out;
    logic                    busy_in;

    modport slave (
        input  data_in, valid_in, sof_in, busy_in,
        output busy_out, data_out, valid_out, sof_out
    );

    modport master (
        output data_in, valid_in, sof_in, busy_in,
        input  busy_out, data_out, valid_out, sof_out
    );
endinterface
`default_nettype wire

// File: rtl/datapath_gray_param.sv
`default_nettype none
// ============================================================================
// datapath_gray_param: byte-serial weighted gray converter with a shared
// multiplier, SOF resync and output FIFO. Option macro: DATAPATH_GRAY_ROUND_EN.
// Revision: 1.0
// ============================================================================
module datapath_gray_param #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_CHANNELS   = 3,
    parameter int C_COEF_WIDTH = 8,
    parameter int C_COEF_SHIFT = 7,
    parameter int C_OUT_DEPTH  = 4
) (
    input  wire logic                               i_clk,
    input  wire logic                               i_rst_n,
    input  wire logic [C_CHANNELS*C_COEF_WIDTH-1:0] i_coef,
    datapath_gray_param_if.slave                    s_if,
    output logic                                    o_sync_err
);
    localparam int CH_W   = $clog2(C_CHANNELS);
    localparam int NCOEF  = 1 << CH_W;
    localparam int PROD_W = C_DATA_WIDTH + C_COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(C_CHANNELS);
    localparam int PTR_W  = $clog2(C_OUT_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OCC_W  = CNT_W + 2;
    localparam int LAT_W  = (C_CHANNELS - 1) * C_COEF_WIDTH;
    localparam logic [ACC_W:0] DATA_MAX = {{(ACC_W + 1 - C_DATA_WIDTH){1'b0}}, {C_DATA_WIDTH{1'b1}}};
`ifdef DATAPATH_GRAY_ROUND_EN
    localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (C_COEF_SHIFT - 1);
`else
    localparam logic [ACC_W:0] RND = '0;
`endif

    logic [CH_W-1:0]         ch_q, ch_d;
    logic [LAT_W-1:0]        coef_q;
    logic                    s1_vld_q, s1_first_q, s1_last_q, s1_sof_q;
    logic [PROD_W-1:0]       s1_prod_q;
    logic [ACC_W-1:0]        acc_q;
    logic                    s2_last_q, s2_sof_q;
    logic                    s3_vld_q, s3_sof_q;
    logic [C_DATA_WIDTH-1:0] s3_data_q;
    logic                    sync_err_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [C_DATA_WIDTH-1:0] mem_data_q [C_OUT_DEPTH];
    logic                    mem_sof_q  [C_OUT_DEPTH];

    logic                    w_accept, w_resync, w_last, w_busy, w_push, w_pop, w_valid;
    logic [CH_W-1:0]         w_ch;
    logic [C_COEF_WIDTH-1:0] w_coef_arr [NCOEF];
    logic [PROD_W-1:0]       w_prod;
    logic [ACC_W:0]          w_round, w_shift;
    logic [C_DATA_WIDTH-1:0] w_sat;
    logic [OCC_W-1:0]        w_occ;

    // Channel 0 multiplies with the live coefficient; the rest use the copy taken on that beat.
    for (genvar k = 0; k < NCOEF; k++) begin : g_coef
        if (k == 0) begin : g_ch0
            assign w_coef_arr[k] = i_coef[0 +: C_COEF_WIDTH];
        end else if (k < C_CHANNELS) begin : g_lat
            assign w_coef_arr[k] = coef_q[(k - 1) * C_COEF_WIDTH +: C_COEF_WIDTH];
        end else begin : g_pad
            assign w_coef_arr[k] = '0;
        end
    end

    // Occupancy counts finished pixels still in the pipe so the FIFO can never overflow.
    assign w_occ    = OCC_W'(cnt_q) + OCC_W'(s1_vld_q & s1_last_q) + OCC_W'(s2_last_q) + OCC_W'(s3_vld_q);
    assign w_busy   = w_occ >= OCC_W'(C_OUT_DEPTH);
    assign w_accept = s_if.valid_in && !w_busy;
    assign w_resync = w_accept && s_if.sof_in && (ch_q != '0);
    assign w_ch     = w_resync ? '0 : ch_q;
    assign w_last   = (w_ch == CH_W'(C_CHANNELS - 1));
    assign w_prod   = PROD_W'(s_if.data_in) * PROD_W'(w_coef_arr[w_ch]);

    assign w_round  = {1'b0, acc_q} + RND;
    assign w_shift  = w_round >> C_COEF_SHIFT;
    assign w_sat    = (w_shift > DATA_MAX) ? DATA_MAX[C_DATA_WIDTH-1:0] : w_shift[C_DATA_WIDTH-1:0];

    assign w_valid  = (cnt_q != '0);
    assign w_push   = s3_vld_q;
    assign w_pop    = w_valid && !s_if.busy_in;

    always_comb begin
        ch_d = ch_q;
        if (w_accept) begin
            ch_d = w_last ? '0 : w_ch + CH_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch_q       <= '0;
            coef_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_prod_q  <= '0;
            acc_q      <= '0;
            s2_last_q  <= 1'b0;
            s2_sof_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            s3_sof_q   <= 1'b0;
            s3_data_q  <= '0;
            sync_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ch_q       <= ch_d;
            sync_err_q <= w_resync;
            if (w_accept && (w_ch == '0)) begin
                coef_q <= i_coef[C_CHANNELS*C_COEF_WIDTH-1:C_COEF_WIDTH];
            end
            s1_vld_q <= w_accept;
            if (w_accept) begin
                s1_prod_q  <= w_prod;
                s1_first_q <= (w_ch == '0);
                s1_last_q  <= w_last;
                s1_sof_q   <= s_if.sof_in;
            end
            s2_last_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                acc_q <= s1_first_q ? ACC_W'(s1_prod_q) : acc_q + ACC_W'(s1_prod_q);
                if (s1_first_q) begin
                    s2_sof_q <= s1_sof_q;
                end
            end
            s3_vld_q <= s2_last_q;
            if (s2_last_q) begin
                s3_data_q <= w_sat;
                s3_sof_q  <= s2_sof_q;
            end
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_data_q[wr_ptr_q] <= s3_data_q;
            mem_sof_q[wr_ptr_q]  <= s3_sof_q;
        end
    end

    assign s_if.busy_out  = w_busy;
    assign s_if.valid_out = w_valid;
    assign s_if.data_out  = w_valid ? mem_data_q[rd_ptr_q] : '0;
    assign s_if.sof_out   = w_valid ? mem_sof_q[rd_ptr_q] : 1'b0;
    assign o_sync_err     = sync_err_q;
endmodule
`default_nettype wire

// File: tb/tb_datapath_gray_param.sv
`default_nettype none
// ============================================================================
// tb_datapath_gray_param: directed self-checking bench for datapath_gray_param.
// Revision: 1.0
// ============================================================================
module tb_datapath_gray_param;
    logic        clk;
    logic        rst_n;
    logic [23:0] coef;
    logic        sync_err;
    int          n_pass;
    int          n_total;
    int          n_fail;

    datapath_gray_param_if #(.C_DATA_WIDTH(8)) u_if ();

    datapath_gray_param u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_coef     (coef),
        .s_if       (u_if),
        .o_sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pack(input int c0, input int c1, input int c2);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    // Reference gray value for coefficients (38,75,15)
    function automatic int gray_ref(input int r, input int g, input int b);
        int s;
        s = 38 * r + 75 * g + 15 * b;
`ifdef DATAPATH_GRAY_ROUND_EN
        s = s + 64;
`endif
        s = s >> 7;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int d, input logic s);
        u_if.data_in  = 8'(d);
        u_if.valid_in = 1'b1;
        u_if.sof_in   = s;
        tick();
        u_if.valid_in = 1'b0;
        u_if.sof_in   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int exp_d, input logic exp_s);
        int n;
        n = 0;
        while (!u_if.valid_out && n < 30) begin
            tick();
            n++;
        end
        check({tag, " valid"}, 32'(u_if.valid_out), 32'd1);
        check({tag, " data"},  32'(u_if.data_out),  32'(exp_d));
        check({tag, " sof"},   32'(u_if.sof_out),   32'(exp_s));
        tick();
    endtask

    int pix [6][3];
    int pop_cyc [6];

    initial begin
        int  bi;
        int  npop;
        logic acc;
        logic pop;
        int  exp_main;

        n_pass = 0; n_total = 0; n_fail = 0;
        rst_n = 1'b0;
        coef  = pack(38, 75, 15);
        u_if.data_in  = '0;
        u_if.valid_in = 1'b0;
        u_if.sof_in   = 1'b0;
        u_if.busy_in  = 1'b0;
`ifdef DATAPATH_GRAY_ROUND_EN
        exp_main = 153;
`else
        exp_main = 152;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("reset valid_out", 32'(u_if.valid_out), 32'd0);
        check("reset data_out",  32'(u_if.data_out),  32'd0);
        check("reset sof_out",   32'(u_if.sof_out),   32'd0);
        check("reset busy_out",  32'(u_if.busy_out),  32'd0);
        check("reset sync_err",  32'(sync_err),       32'd0);

        // Basic pixel and latency: valid_out appears on the third edge after the last beat
        beat(100, 1'b0);
        beat(200, 1'b0);
        beat(50, 1'b0);
        check("lat e0", 32'(u_if.valid_out), 32'd0);
        tick();
        check("lat e1", 32'(u_if.valid_out), 32'd0);
        tick();
        check("lat e2", 32'(u_if.valid_out), 32'd0);
        tick();
        check("lat e3 valid", 32'(u_if.valid_out), 32'd1);
        check("lat e3 data",  32'(u_if.data_out),  32'(exp_main));
        check("lat e3 sof",   32'(u_if.sof_out),   32'd0);
        tick();
        check("pop valid", 32'(u_if.valid_out), 32'd0);

        // Saturation and zero
        coef = pack(255, 255, 255);
        beat(255, 1'b1);
        beat(255, 1'b0);
        beat(255, 1'b0);
        expect_out("sat", 255, 1'b1);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        expect_out("zero", 0, 1'b0);

        // Backpressure: six pixels streamed against a stalled output
        coef = pack(38, 75, 15);
        pix[0] = '{10, 20, 30};
        pix[1] = '{255, 0, 0};
        pix[2] = '{0, 255, 0};
        pix[3] = '{0, 0, 255};
        pix[4] = '{128, 128, 128};
        pix[5] = '{1, 2, 3};
        u_if.busy_in = 1'b1;
        bi = 0;
        for (int c = 0; c < 40; c++) begin
            u_if.valid_in = (bi < 18);
            u_if.data_in  = (bi < 18) ? 8'(pix[bi / 3][bi % 3]) : 8'd0;
            acc = u_if.valid_in && !u_if.busy_out;
            tick();
            if (acc) bi++;
        end
        check("bp beats accepted", 32'(bi), 32'd12);
        check("bp busy_out",       32'(u_if.busy_out),  32'd1);
        check("bp valid_out held", 32'(u_if.valid_out), 32'd1);
        check("bp head held",      32'(u_if.data_out),  32'(gray_ref(10, 20, 30)));

        u_if.busy_in = 1'b0;
        npop = 0;
        for (int c = 0; c < 100 && npop < 6; c++) begin
            u_if.valid_in = (bi < 18);
            u_if.data_in  = (bi < 18) ? 8'(pix[bi / 3][bi % 3]) : 8'd0;
            acc = u_if.valid_in && !u_if.busy_out;
            pop = u_if.valid_out && !u_if.busy_in;
            if (pop) begin
                check($sformatf("drain %0d", npop), 32'(u_if.data_out),
                      32'(gray_ref(pix[npop][0], pix[npop][1], pix[npop][2])));
                pop_cyc[npop] = c;
                npop++;
            end
            tick();
            if (acc) bi++;
        end
        u_if.valid_in = 1'b0;
        check("drain count", 32'(npop), 32'd6);
        check("drain back-to-back", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
        repeat (2) tick();
        check("drain empty", 32'(u_if.valid_out), 32'd0);

        // SOF resync mid-pixel
        beat(10, 1'b1);
        check("resync err b1", 32'(sync_err), 32'd0);
        beat(20, 1'b0);
        check("resync err b2", 32'(sync_err), 32'd0);
        beat(30, 1'b1);
        check("resync err pulse", 32'(sync_err), 32'd1);
        beat(40, 1'b0);
        check("resync err drop", 32'(sync_err), 32'd0);
        beat(50, 1'b0);
        expect_out("resync", 38, 1'b1);
        repeat (8) tick();
        check("resync single output", 32'(u_if.valid_out), 32'd0);

        // Coefficients latched on channel 0
        coef = pack(38, 75, 15);
        beat(100, 1'b0);
        coef = pack(255, 255, 255);
        beat(200, 1'b0);
        beat(50, 1'b0);
        expect_out("coef latch", exp_main, 1'b0);

        // Asynchronous reset with FIFO occupied and a partial pixel in flight
        coef = pack(38, 75, 15);
        u_if.busy_in = 1'b1;
        beat(10, 1'b1);
        beat(20, 1'b0);
        beat(30, 1'b0);
        bi = 0;
        while (!u_if.valid_out && bi < 20) begin
            tick();
            bi++;
        end
        check("pre-rst valid", 32'(u_if.valid_out), 32'd1);
        check("pre-rst data",  32'(u_if.data_out),  32'(gray_ref(10, 20, 30)));
        check("pre-rst sof",   32'(u_if.sof_out),   32'd1);
        beat(5, 1'b0);
        beat(7, 1'b1);
        check("pre-rst sync_err", 32'(sync_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst valid_out", 32'(u_if.valid_out), 32'd0);
        check("arst sof_out",   32'(u_if.sof_out),   32'd0);
        check("arst sync_err",  32'(sync_err),       32'd0);
        check("arst data_out",  32'(u_if.data_out),  32'd0);
        #2 rst_n = 1'b1;
        u_if.busy_in = 1'b0;
        tick();
        beat(100, 1'b0);
        beat(200, 1'b0);
        beat(50, 1'b0);
        expect_out("post-rst", exp_main, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
